cp0_ctrl_param: RTL and testbench
=================================

// Module: cp0_ctrl_param
// PURPOSE
//  Parametrised CP0 controller at the WB stage: Status/Cause/EPC/Count/Compare/BadVAddr, timer and interrupt logic.
//  Commits one WB-stage instruction per cycle. Resolves interrupt > exception > eret > mtc0 priority.
//  Drives pipeline flush and redirect target. Serves mfc0 reads.
//  Adds over the previous CP0: configurable hw-int count, Count prescaler, timer interrupt (Cause.TI), BD-aware EPC.
// PARAMETERS
//  NUM_HW_INT  6             hardware int lines (1..6), mapped to Cause.IP[2+:NUM_HW_INT]
//  COUNT_DIV   2             Count increments once every COUNT_DIV cycles (1..16)
//  EXC_VECTOR  32'hBFC00380  redirect target for interrupts/exceptions
//  TIMER_IP    7             IP bit (2..7) the timer request is ORed into
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  wb_valid      in   1   WB holds a valid instruction
//  wb_exception  in   1   instruction carries a synchronous exception
//  wb_exccode    in   5   its ExcCode (4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
//  wb_bd         in   1   instruction is in a branch delay slot
//  wb_pc         in   32  instruction PC
//  wb_badvaddr   in   32  faulting address (meaningful for ExcCode 4/5)
//  wb_eret       in   1   instruction is eret
//  wb_mtc0       in   1   instruction is mtc0
//  wb_cp0_addr   in   8   {rd[4:0],sel[2:0]}: 8'h40 BadVAddr, 48 Count, 58 Compare, 60 Status, 68 Cause, 70 EPC
//  wb_mtc0_data  in   32  mtc0 write data
//  ext_int       in   NUM_HW_INT  level-sensitive external interrupts
//  cp0_rdata     out  32  mfc0 read data for wb_cp0_addr
//  flush         out  1   clear pipeline and redirect this cycle
//  flush_target  out  32  redirect PC, valid while flush=1
// BEHAVIOUR
//  Reset: Status=32'h0040_0000 (BEV=1, IM=0, EXL=0, IE=0). Cause, EPC, Count, Compare, BadVAddr, prescaler = 0.
//  Reset: ext_int sample reg = 0. Outputs follow the combinational rules below (flush=0 while wb_valid=0).
//  Status: IM[15:8], EXL[1], IE[0] writable. BEV[22] reads constant 1. All other bits read 0.
//  Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] (soft ints) writable by mtc0.
//  Hw IP: IP[2+i] = registered ext_int[i] (1-cycle sample) for i<NUM_HW_INT. IP[TIMER_IP] additionally ORed with TI.
//  Unused IP bits read 0.
//  int_req = |(Cause.IP & Status.IM) & IE & ~EXL. Taken only when wb_valid=1, so an interrupt waits for a valid WB slot.
//  Event select, one per cycle, gated by wb_valid:
//    int_req > wb_exception > wb_eret > wb_mtc0. A lower event is suppressed; no write occurs.
//  Interrupt/exception, same cycle:
//    flush=1, flush_target=EXC_VECTOR.
//    Next edge: ExcCode = 0 (int) or wb_exccode; EXL=1.
//    If EXL was 0: EPC = wb_bd ? wb_pc-4 : wb_pc, and BD=wb_bd. If EXL was 1: EPC and BD hold.
//    BadVAddr = wb_badvaddr only when the exception is taken with ExcCode 4 or 5; otherwise it holds.
//  eret: flush=1, flush_target=EPC (current register value). Next edge: EXL=0.
//  mtc0: written at the next edge to the register selected by wb_cp0_addr. Unmapped addresses are ignored.
//  mfc0: cp0_rdata combinational from current register values, i.e. the pre-write value. Unmapped address -> 0.
//  Count: prescaler counts 0..COUNT_DIV-1 and produces a tick on wrap. On a tick, Count += 1, wrapping 32'hFFFFFFFF -> 0.
//    mtc0 Count loads the data and clears the prescaler; this overrides a same-cycle tick.
//  TI: set at the edge where a tick makes Count+1 == Compare. Sticky.
//    Cleared by mtc0 Compare, and the clear beats a same-cycle set.
//    TI is never set by reset equality (0==0).
//  Simultaneous int_req and wb_mtc0 to Status: the interrupt wins and the mtc0 is dropped.
//  Reset asserted mid-operation overrides every event in that cycle.
// TESTING
//  1 Reset then idle 10 cycles, COUNT_DIV=2 -> Count=5, TI=0, Status reads 32'h0040_0000, flush=0.
//  2 mtc0 Compare=3, Count=0; then mtc0 Status=32'h0000_8001 (IM7, IE) with WB kept valid
//    -> TI=1 after the 6th cycle. Next valid cycle: flush=1, target 32'hBFC00380, ExcCode=0, EXL=1.
//  3 wb_exception, code 4, pc=32'h8000_0010, bd=1, badvaddr=32'h1233
//    -> EPC=32'h8000_000C, BD=1, BadVAddr=32'h1233, ExcCode=4.
//  4 Second exception while EXL=1, code 12, pc=32'h8000_0100 -> EPC unchanged, ExcCode=12, BadVAddr unchanged.
//  5 eret with EPC=32'h8000_0020 -> flush=1, flush_target=32'h8000_0020, EXL=0 next cycle.
//  6 ext_int[0] high with IM2=1, IE=1, and wb_mtc0 Status in the same cycle
//    -> interrupt taken 1 cycle after the sample, Status write dropped.

Source files
------------

// File: rtl/cp0_ctrl_param.sv
// CP0 controller at WB: Status/Cause/EPC/Count/Compare/BadVAddr, timer and interrupt logic.
// Flush and redirect are combinational on the WB slot; all register updates land on the next edge.
module cp0_ctrl_param #(
   parameter int          NUM_HW_INT = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter int          TIMER_IP   = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_valid,
   input  logic                  wb_exception,
   input  logic [4:0]            wb_exccode,
   input  logic                  wb_bd,
   input  logic [31:0]           wb_pc,
   input  logic [31:0]           wb_badvaddr,
   input  logic                  wb_eret,
   input  logic                  wb_mtc0,
   input  logic [7:0]            wb_cp0_addr,
   input  logic [31:0]           wb_mtc0_data,
   input  logic [NUM_HW_INT-1:0] ext_int,
   output logic [31:0]           cp0_rdata,
   output logic                  flush,
   output logic [31:0]           flush_target
);

   localparam logic [7:0] A_BADVADDR = 8'h40;
   localparam logic [7:0] A_COUNT    = 8'h48;
   localparam logic [7:0] A_COMPARE  = 8'h58;
   localparam logic [7:0] A_STATUS   = 8'h60;
   localparam logic [7:0] A_CAUSE    = 8'h68;
   localparam logic [7:0] A_EPC      = 8'h70;
   localparam logic [3:0] PRESC_MAX  = 4'(COUNT_DIV - 1);

   logic [7:0]            r_status_im;
   logic                  r_exl;
   logic                  r_ie;
   logic                  r_bd;
   logic                  r_ti;
   logic [1:0]            r_ip_sw;
   logic [4:0]            r_exccode;
   logic [31:0]           r_epc;
   logic [31:0]           r_count;
   logic [31:0]           r_compare;
   logic [31:0]           r_badvaddr;
   logic [3:0]            r_presc;
   logic [NUM_HW_INT-1:0] r_ext_int;

   logic [7:0]  w_ip;
   logic        w_int_req;
   logic        w_take_int;
   logic        w_take_exc;
   logic        w_take_eret;
   logic        w_take_mtc0;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_tick;
   logic [31:0] w_count_inc;
   logic [31:0] w_status;
   logic [31:0] w_cause;

   // Hardware lines come from the sampled copy; the timer shares one IP bit.
   always_comb begin
      w_ip = {6'b0, r_ip_sw};
      for (int i = 0; i < NUM_HW_INT; i++) begin
         w_ip[2+i] = r_ext_int[i];
      end
      w_ip[TIMER_IP] = w_ip[TIMER_IP] | r_ti;
   end

   assign w_int_req    = (|(w_ip & r_status_im)) & r_ie & ~r_exl;
   assign w_take_int   = wb_valid & w_int_req;
   assign w_take_exc   = wb_valid & ~w_int_req & wb_exception;
   assign w_take_eret  = wb_valid & ~w_int_req & ~wb_exception & wb_eret;
   assign w_take_mtc0  = wb_valid & ~w_int_req & ~wb_exception & ~wb_eret & wb_mtc0;
   assign w_wr_count   = w_take_mtc0 & (wb_cp0_addr == A_COUNT);
   assign w_wr_compare = w_take_mtc0 & (wb_cp0_addr == A_COMPARE);
   assign w_tick       = (r_presc == PRESC_MAX);
   assign w_count_inc  = r_count + 32'd1;

   assign flush        = w_take_int | w_take_exc | w_take_eret;
   assign flush_target = w_take_eret ? r_epc : EXC_VECTOR;

   assign w_status = {9'b0, 1'b1, 6'b0, r_status_im, 6'b0, r_exl, r_ie};
   assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};

   always_comb begin
      cp0_rdata = 32'b0;
      case (wb_cp0_addr)
         A_BADVADDR: cp0_rdata = r_badvaddr;
         A_COUNT:    cp0_rdata = r_count;
         A_COMPARE:  cp0_rdata = r_compare;
         A_STATUS:   cp0_rdata = w_status;
         A_CAUSE:    cp0_rdata = w_cause;
         A_EPC:      cp0_rdata = r_epc;
         default:    cp0_rdata = 32'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status_im <= '0;
         r_exl       <= 1'b0;
         r_ie        <= 1'b0;
         r_bd        <= 1'b0;
         r_ti        <= 1'b0;
         r_ip_sw     <= '0;
         r_exccode   <= '0;
         r_epc       <= '0;
         r_count     <= '0;
         r_compare   <= '0;
         r_badvaddr  <= '0;
         r_presc     <= '0;
         r_ext_int   <= '0;
      end else begin
         r_ext_int <= ext_int;

         // A Count write restarts the prescaler and swallows a coincident tick.
         if (w_wr_count) begin
            r_count <= wb_mtc0_data;
            r_presc <= '0;
         end else begin
            r_presc <= w_tick ? 4'd0 : r_presc + 4'd1;
            if (w_tick) r_count <= w_count_inc;
         end

         if (w_wr_compare) r_ti <= 1'b0;
         else if (w_tick && !w_wr_count && (w_count_inc == r_compare)) r_ti <= 1'b1;

         if (w_take_int || w_take_exc) begin
            r_exccode <= w_take_int ? 5'd0 : wb_exccode;
            r_exl     <= 1'b1;
            if (!r_exl) begin
               r_epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
               r_bd  <= wb_bd;
            end
            if (w_take_exc && (wb_exccode == 5'd4 || wb_exccode == 5'd5))
               r_badvaddr <= wb_badvaddr;
         end else if (w_take_eret) begin
            r_exl <= 1'b0;
         end else if (w_take_mtc0) begin
            case (wb_cp0_addr)
               A_BADVADDR: r_badvaddr <= wb_mtc0_data;
               A_COMPARE:  r_compare  <= wb_mtc0_data;
               A_STATUS: begin
                  r_status_im <= wb_mtc0_data[15:8];
                  r_exl       <= wb_mtc0_data[1];
                  r_ie        <= wb_mtc0_data[0];
               end
               A_CAUSE:    r_ip_sw    <= wb_mtc0_data[9:8];
               A_EPC:      r_epc      <= wb_mtc0_data;
               default:    ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cp0_ctrl_param.sv
// Directed scoreboard bench for cp0_ctrl_param: expectations queued at drive time, checked mid-cycle.
module tb_cp0_ctrl_param;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, wb_exception, wb_bd, wb_eret, wb_mtc0;
   logic [4:0]  wb_exccode;
   logic [31:0] wb_pc, wb_badvaddr, wb_mtc0_data;
   logic [7:0]  wb_cp0_addr;
   logic [5:0]  ext_int;
   logic [31:0] cp0_rdata, flush_target;
   logic        flush;

   int nchk = 0;
   int nerr = 0;

   int          sel_q[$];
   string       tag_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   cp0_ctrl_param dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_exception(wb_exception),
      .wb_exccode(wb_exccode), .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
      .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .wb_cp0_addr(wb_cp0_addr),
      .wb_mtc0_data(wb_mtc0_data), .ext_int(ext_int), .cp0_rdata(cp0_rdata),
      .flush(flush), .flush_target(flush_target)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   task automatic push(input int s, input string t, input logic [31:0] v);
      sel_q.push_back(s);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic ef(input string t, input logic f, input logic [31:0] tg);
      push(0, {t, "_flush"}, {31'b0, f});
      if (f) push(1, {t, "_target"}, tg);
   endtask

   task automatic er(input string t, input logic [31:0] v);
      push(2, t, v);
   endtask

   task automatic drain();
      int s;
      string t;
      logic [31:0] e;
      while (sel_q.size() > 0) begin
         s = sel_q.pop_front();
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         case (s)
            0:       chk(t, {31'b0, flush}, e);
            1:       chk(t, flush_target, e);
            default: chk(t, cp0_rdata, e);
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      wb_valid = 0; wb_exception = 0; wb_exccode = 0; wb_bd = 0; wb_pc = 0;
      wb_badvaddr = 0; wb_eret = 0; wb_mtc0 = 0; wb_cp0_addr = 0; wb_mtc0_data = 0;
   endtask

   task automatic rd(input string t, input logic [7:0] a, input logic [31:0] v);
      clr();
      wb_cp0_addr = a;
      er(t, v);
      ef(t, 1'b0, 32'h0);
      tick();
   endtask

   task automatic mt(input logic [7:0] a, input logic [31:0] d);
      clr();
      wb_valid = 1; wb_mtc0 = 1; wb_cp0_addr = a; wb_mtc0_data = d;
   endtask

   task automatic nop(input logic [31:0] pc, input logic [7:0] a);
      clr();
      wb_valid = 1; wb_pc = pc; wb_cp0_addr = a;
   endtask

   task automatic exc(input logic [4:0] c, input logic [31:0] pc, input logic bd,
                      input logic [31:0] bva);
      clr();
      wb_valid = 1; wb_exception = 1; wb_exccode = c; wb_pc = pc; wb_bd = bd; wb_badvaddr = bva;
   endtask

   initial begin
      rst = 1; ext_int = '0; clr();
      for (int i = 0; i < 2; i++) begin ef("rst", 1'b0, 32'h0); tick(); end
      rst = 0;

      // Reset values and idle Count progression
      rd("rst_count", 8'h48, 32'h0);
      rd("rst_status", 8'h60, 32'h0040_0000);
      rd("rst_cause", 8'h68, 32'h0);
      rd("rst_epc", 8'h70, 32'h0);
      rd("rst_badva", 8'h40, 32'h0);
      rd("rst_compare", 8'h58, 32'h0);
      rd("unmapped", 8'h00, 32'h0);
      rd("unmapped_ff", 8'hFF, 32'h0);
      for (int i = 0; i < 2; i++) begin clr(); ef("idle", 1'b0, 32'h0); tick(); end
      rd("idle10_count", 8'h48, 32'd5);
      rd("idle_status", 8'h60, 32'h0040_0000);
      rd("idle_cause", 8'h68, 32'h0);

      // Timer interrupt
      mt(8'h58, 32'd3); er("pre_compare", 32'h0); ef("mt_cmp", 1'b0, 32'h0); tick();
      mt(8'h48, 32'd0); er("pre_count", 32'd7); ef("mt_cnt", 1'b0, 32'h0); tick();
      mt(8'h60, 32'h0000_8001); er("pre_status", 32'h0040_0000); ef("mt_st", 1'b0, 32'h0); tick();
      for (int i = 0; i < 5; i++) begin
         nop(32'h8000_0040, 8'h68); er("ti_wait_cause", 32'h0); ef("ti_wait", 1'b0, 32'h0); tick();
      end
      nop(32'h8000_0040, 8'h68); er("ti_cause", 32'h4000_8000); ef("tint", 1'b1, VEC); tick();
      rd("tint_status", 8'h60, 32'h0040_8003);
      rd("tint_epc", 8'h70, 32'h8000_0040);
      rd("tint_cause", 8'h68, 32'h4000_8000);
      mt(8'h58, 32'h1000); er("pre_cmp2", 32'd3); ef("mt_cmp2", 1'b0, 32'h0); tick();
      mt(8'h60, 32'h0); er("pre_st2", 32'h0040_8003); ef("mt_st2", 1'b0, 32'h0); tick();
      rd("ti_clr_cause", 8'h68, 32'h0);

      // Exception in delay slot, then nested exception with eret also set
      exc(5'd4, 32'h8000_0010, 1'b1, 32'h1233); ef("adel", 1'b1, VEC); tick();
      rd("adel_epc", 8'h70, 32'h8000_000C);
      rd("adel_cause", 8'h68, 32'h8000_0010);
      rd("adel_badva", 8'h40, 32'h1233);
      rd("adel_status", 8'h60, 32'h0040_0002);
      exc(5'd12, 32'h8000_0100, 1'b0, 32'hDEAD); wb_eret = 1; ef("ov_nested", 1'b1, VEC); tick();
      rd("ov_epc", 8'h70, 32'h8000_000C);
      rd("ov_cause", 8'h68, 32'h8000_0030);
      rd("ov_badva", 8'h40, 32'h1233);
      rd("ov_status", 8'h60, 32'h0040_0002);

      // eret, with a suppressed same-cycle mtc0 EPC
      mt(8'h70, 32'h8000_0020); er("pre_epc", 32'h8000_000C); ef("mt_epc", 1'b0, 32'h0); tick();
      mt(8'h70, 32'h1234_5678); wb_eret = 1; er("eret_epc", 32'h8000_0020);
      ef("eret", 1'b1, 32'h8000_0020); tick();
      rd("eret_status", 8'h60, 32'h0040_0000);
      rd("eret_epc_kept", 8'h70, 32'h8000_0020);

      // External interrupt beats same-cycle Status write
      mt(8'h60, 32'h0000_0401); ef("mt_im2", 1'b0, 32'h0); tick();
      nop(32'h8000_0180, 8'h00); ext_int = 6'b000001; ef("hw_presample", 1'b0, 32'h0); tick();
      mt(8'h60, 32'h0000_FF01); wb_pc = 32'h8000_0200; ef("hw_int", 1'b1, VEC); tick();
      rd("hw_cause", 8'h68, 32'h0000_0400);
      ext_int = '0;
      rd("hw_status", 8'h60, 32'h0040_0403);
      rd("hw_epc", 8'h70, 32'h8000_0200);

      // Reset mid-operation overrides a pending exception
      exc(5'd5, 32'h9000_0000, 1'b0, 32'h55); rst = 1; tick();
      rst = 0;
      rd("mrst_epc", 8'h70, 32'h0);
      rd("mrst_status", 8'h60, 32'h0040_0000);
      rd("mrst_badva", 8'h40, 32'h0);

      // Count wrap to 0 matches Compare=0 and raises TI
      mt(8'h48, 32'hFFFF_FFFE); er("pre_cnt_wrap", 32'd1); ef("mt_wrap", 1'b0, 32'h0); tick();
      for (int i = 0; i < 2; i++) begin clr(); ef("wrap_idle", 1'b0, 32'h0); tick(); end
      rd("cnt_max", 8'h48, 32'hFFFF_FFFF);
      clr(); ef("wrap_idle", 1'b0, 32'h0); tick();
      rd("cnt_wrap", 8'h48, 32'h0);
      rd("wrap_ti", 8'h68, 32'h4000_8000);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nerr);
      $finish;
   end

endmodule
